// File: rtl/ame_sobel_ctrl.sv
// Block sequencer for the AME Sobel 4x4 datapath: walks a CU of 4x4 blocks in raster
// order, fetching six lines per block, feeding the Sobel core and handing results downstream.
module ame_sobel_ctrl #(
  parameter int BLK_X_MAX      = 16,
  parameter int BLK_Y_MAX      = 16,
  parameter int LINE_DATA_BITS = 8,
  parameter int LINE_IDX_BITS  = 6
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        dir_i,
  input  logic [4:0]                  blk_x_num_i,
  input  logic [4:0]                  blk_y_num_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        mem_rd_en_o,
  output logic [LINE_IDX_BITS-1:0]    mem_rd_line_o,
  output logic [LINE_IDX_BITS-1:0]    mem_rd_ofs_o,
  input  logic [6*LINE_DATA_BITS-1:0] mem_rd_data_i,
  output logic                        sobel_init_o,
  output logic [6*LINE_DATA_BITS-1:0] sobel_line_o,
  input  logic                        sobel_done_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [3:0]                  res_bx_o,
  output logic [3:0]                  res_by_o
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, OUT, DONE} state_t;

  state_t     state;
  logic       dir;
  logic [4:0] x_num, y_num;
  logic [3:0] bx, by;
  logic [2:0] k;
  logic       last_bx, last_blk;
  logic [3:0] nxt_bx, nxt_by;

  function automatic logic [4:0] clamp_dim(input logic [4:0] d, input int mx);
    if (d == 5'd0) return 5'd1;
    if (int'(d) > mx) return 5'(mx);
    return d;
  endfunction

  // Line index along the filter axis, edge-clamped to the CU extent.
  function automatic logic [LINE_IDX_BITS-1:0] line_idx(input logic d, input logic [3:0] x,
      input logic [3:0] y, input logic [4:0] xn, input logic [4:0] yn, input logic [2:0] kk);
    int a, hi, v;
    a  = d ? int'(y) : int'(x);
    hi = 4 * (d ? int'(yn) : int'(xn)) - 1;
    v  = 4 * a - 1 + int'(kk);
    if (v < 0) v = 0;
    else if (v > hi) v = hi;
    return LINE_IDX_BITS'(v);
  endfunction

  function automatic logic [LINE_IDX_BITS-1:0] ofs_idx(input logic d, input logic [3:0] x,
      input logic [3:0] y);
    return LINE_IDX_BITS'({(d ? x : y), 2'b00});
  endfunction

  assign sobel_line_o = mem_rd_data_i;
  assign last_bx      = ({1'b0, bx} == x_num - 5'd1);
  assign last_blk     = last_bx && ({1'b0, by} == y_num - 5'd1);
  assign nxt_bx       = last_bx ? 4'd0 : bx + 4'd1;
  assign nxt_by       = last_bx ? by + 4'd1 : by;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      dir           <= 1'b0;
      x_num         <= 5'd1;
      y_num         <= 5'd1;
      bx            <= '0;
      by            <= '0;
      k             <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      mem_rd_en_o   <= 1'b0;
      mem_rd_line_o <= '0;
      mem_rd_ofs_o  <= '0;
      sobel_init_o  <= 1'b0;
      res_valid_o   <= 1'b0;
      res_bx_o      <= '0;
      res_by_o      <= '0;
    end else begin
      done_o       <= 1'b0;
      sobel_init_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          dir           <= dir_i;
          x_num         <= clamp_dim(blk_x_num_i, BLK_X_MAX);
          y_num         <= clamp_dim(blk_y_num_i, BLK_Y_MAX);
          bx            <= '0;
          by            <= '0;
          k             <= '0;
          busy_o        <= 1'b1;
          mem_rd_en_o   <= 1'b1;
          mem_rd_line_o <= '0;
          mem_rd_ofs_o  <= '0;
          state         <= FETCH;
        end
        FETCH: begin
          // Init rides with the k=0 data, which arrives one cycle after its read.
          sobel_init_o <= (k == 3'd0);
          if (k == 3'd5) begin
            mem_rd_en_o   <= 1'b0;
            mem_rd_line_o <= '0;
            mem_rd_ofs_o  <= '0;
            state         <= WAIT;
          end else begin
            k             <= k + 3'd1;
            mem_rd_line_o <= line_idx(dir, bx, by, x_num, y_num, k + 3'd1);
          end
        end
        WAIT: if (sobel_done_i) begin
          res_valid_o <= 1'b1;
          res_bx_o    <= bx;
          res_by_o    <= by;
          state       <= OUT;
        end
        OUT: if (res_ready_i) begin
          res_valid_o <= 1'b0;
          if (last_blk) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= DONE;
          end else begin
            bx            <= nxt_bx;
            by            <= nxt_by;
            k             <= '0;
            mem_rd_en_o   <= 1'b1;
            mem_rd_line_o <= line_idx(dir, nxt_bx, nxt_by, x_num, y_num, 3'd0);
            mem_rd_ofs_o  <= ofs_idx(dir, nxt_bx, nxt_by);
            state         <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
